// File: rtl/inst_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// master: fetch+decode side; slave: the queue itself.
interface inst_queue_if;
  logic        enq_valid;
  logic [31:0] enq_pc;
  logic [31:0] enq_inst;
  logic        enq_ready;
  logic        deq;
  logic        valid_inst;
  logic [63:0] queue_packet;

  modport master (
    output enq_valid,
    output enq_pc,
    output enq_inst,
    output deq,
    input  enq_ready,
    input  valid_inst,
    input  queue_packet
  );

  modport slave (
    input  enq_valid,
    input  enq_pc,
    input  enq_inst,
    input  deq,
    output enq_ready,
    output valid_inst,
    output queue_packet
  );
endinterface

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: show-ahead FIFO of {pc, inst}.
// Ports: clk, rst (async active-low), branch_mispredict, q (slave), count/full/empty.
module inst_queue #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_mispredict,
  inst_queue_if.slave      q,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [63:0]  mem [DEPTH];
  logic [PTR_W:0] head_ptr, tail_ptr;
  logic [PTR_W:0] head_nxt, tail_nxt;
  logic         enq_fire;
  logic         deq_fire;

  assign empty = (head_ptr == tail_ptr);
  // Same slot index, opposite lap: every slot is occupied.
  assign full  = (head_ptr[PTR_W-1:0] == tail_ptr[PTR_W-1:0]) &&
                 (head_ptr[PTR_W] != tail_ptr[PTR_W]);
  assign count = tail_ptr - head_ptr;

  assign q.enq_ready    = ~full;
  assign q.valid_inst   = ~empty;
  assign q.queue_packet = mem[head_ptr[PTR_W-1:0]];

  assign enq_fire = q.enq_valid && !full && !branch_mispredict;
  assign deq_fire = q.deq && !empty && !branch_mispredict;

  always_comb begin
    head_nxt = head_ptr;
    tail_nxt = tail_ptr;
    if (branch_mispredict) begin
      head_nxt = '0;
      tail_nxt = '0;
    end else begin
      if (enq_fire) tail_nxt = tail_ptr + 1'b1;
      if (deq_fire) head_nxt = head_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      head_ptr <= head_nxt;
      tail_ptr <= tail_nxt;
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (enq_fire)
      mem[tail_ptr[PTR_W-1:0]] <= {q.enq_pc, q.enq_inst};
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue.
// Linear step sequence with immediate assertions at each check.
module tb_inst_queue;
  localparam int DEPTH = 16;
  localparam int PTR_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic branch_mispredict = 1'b0;
  logic [PTR_W:0] count;
  logic full, empty;
  int n_assert = 0;
  int n_fail = 0;

  inst_queue_if qif();

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .branch_mispredict(branch_mispredict),
    .q(qif),
    .count(count),
    .full(full),
    .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    qif.enq_valid = 1'b0;
    qif.enq_pc = '0;
    qif.enq_inst = '0;
    qif.deq = 1'b0;
    branch_mispredict = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    qif.enq_valid = 1'b1;
    qif.enq_pc = pc;
    qif.enq_inst = inst;
    tick();
    qif.enq_valid = 1'b0;
  endtask

  initial begin
    idle_in();
    #2 rst = 1'b0;
    #1;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ready", 64'(qif.enq_ready), 64'd1);
    chk("rst_valid", 64'(qif.valid_inst), 64'd0);

    qif.deq = 1'b1;
    tick();
    tick();
    qif.deq = 1'b0;
    chk("idle_deq_count", 64'(count), 64'd0);
    chk("idle_deq_empty", 64'(empty), 64'd1);

    // Single packet, no bypass
    qif.enq_valid = 1'b1;
    qif.enq_pc = 32'h6000_0000;
    qif.enq_inst = 32'h0000_0013;
    #1;
    chk("single_nobypass", 64'(qif.valid_inst), 64'd0);
    tick();
    qif.enq_valid = 1'b0;
    chk("single_valid", 64'(qif.valid_inst), 64'd1);
    chk("single_pkt", qif.queue_packet, 64'h6000_0000_0000_0013);
    qif.deq = 1'b1;
    tick();
    qif.deq = 1'b0;
    chk("single_drained", 64'(empty), 64'd1);

    // Fill
    for (int i = 0; i < DEPTH; i++)
      push(32'h6000_0000 + 32'(4 * i), 32'(i));
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_count", 64'(count), 64'd16);
    chk("fill_ready", 64'(qif.enq_ready), 64'd0);
    push(32'hDEAD_0000, 32'hDEAD_0001);
    chk("fill_17th", 64'(count), 64'd16);

    // Drain; first step also offers a packet while full
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain_pc%0d", i), 64'(qif.queue_packet[63:32]),
          64'(32'h6000_0000 + 32'(4 * i)));
      chk($sformatf("drain_in%0d", i), 64'(qif.queue_packet[31:0]), 64'(i));
      qif.deq = 1'b1;
      if (i == 0) begin
        qif.enq_valid = 1'b1;
        qif.enq_pc = 32'hDEAD_0000;
      end
      tick();
      qif.deq = 1'b0;
      qif.enq_valid = 1'b0;
      if (i == 0) chk("full_enq_deq", 64'(count), 64'd15);
    end
    chk("drain_empty", 64'(empty), 64'd1);

    // Simultaneous traffic across pointer wrap
    for (int k = 0; k < 5; k++)
      push(32'h7000_0000 + 32'(4 * k), 32'h100 + 32'(k));
    chk("sim_count0", 64'(count), 64'd5);
    for (int j = 0; j < 40; j++) begin
      chk($sformatf("sim_pc%0d", j), 64'(qif.queue_packet[63:32]),
          64'(32'h7000_0000 + 32'(4 * j)));
      qif.enq_valid = 1'b1;
      qif.enq_pc = 32'h7000_0000 + 32'(4 * (j + 5));
      qif.enq_inst = 32'h100 + 32'(j + 5);
      qif.deq = 1'b1;
      tick();
      chk($sformatf("sim_cnt%0d", j), 64'(count), 64'd5);
    end
    idle_in();
    for (int j = 40; j < 45; j++) begin
      chk($sformatf("sim_tail%0d", j), qif.queue_packet,
          {32'h7000_0000 + 32'(4 * j), 32'h100 + 32'(j)});
      qif.deq = 1'b1;
      tick();
      qif.deq = 1'b0;
    end
    chk("sim_empty", 64'(empty), 64'd1);

    // Flush with same-cycle enq and deq
    for (int k = 0; k < 9; k++)
      push(32'h8000_0000 + 32'(4 * k), 32'(k));
    chk("flush_pre", 64'(count), 64'd9);
    branch_mispredict = 1'b1;
    qif.enq_valid = 1'b1;
    qif.enq_pc = 32'hBAD0_0000;
    qif.enq_inst = 32'hBAD0_0001;
    qif.deq = 1'b1;
    tick();
    idle_in();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(qif.valid_inst), 64'd0);
    chk("flush_ready", 64'(qif.enq_ready), 64'd1);
    push(32'h8100_0000, 32'h0000_0033);
    chk("flush_after", qif.queue_packet, 64'h8100_0000_0000_0033);
    chk("flush_after_cnt", 64'(count), 64'd1);
    qif.deq = 1'b1;
    tick();
    qif.deq = 1'b0;

    // Async reset between edges
    for (int k = 0; k < 7; k++)
      push(32'h9000_0000 + 32'(4 * k), 32'(k));
    chk("ar_pre", 64'(count), 64'd7);
    #2 rst = 1'b0;
    #1;
    chk("ar_empty", 64'(empty), 64'd1);
    chk("ar_count", 64'(count), 64'd0);
    chk("ar_valid", 64'(qif.valid_inst), 64'd0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++)
      push(32'hA000_0000 + 32'(4 * k), 32'h200 + 32'(k));
    chk("ar_post_cnt", 64'(count), 64'd3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ar_post%0d", k), qif.queue_packet,
          {32'hA000_0000 + 32'(4 * k), 32'h200 + 32'(k)});
      qif.deq = 1'b1;
      tick();
      qif.deq = 1'b0;
    end
    chk("ar_post_empty", 64'(empty), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
